// File: rtl/ram_wr_ctrl.sv
// Write-side controller for the ADC capture RAM pair (8K parallel-half or 16K MSB-select store).
// Optional trigger arming is enabled with the CAP_WR_TRIG_EN macro (adds the cap_trig port).
module ram_wr_ctrl #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 14
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    capture_start,
   input  logic                    capture_stop,
   input  logic                    capture_loop,
   input  logic                    store_mode,
   input  logic [ADDR_WIDTH-1:0]   capture_max_addr,
   input  logic                    adc_vld,
   input  logic [DATA_WIDTH-1:0]   adc_data,
`ifdef CAP_WR_TRIG_EN
   input  logic                    cap_trig,
`endif
   output logic                    capture_busy,
   output logic                    capture_done,
   output logic                    capture_wrap,
   output logic [ADDR_WIDTH-1:0]   capture_last_addr,
   output logic                    ram0_wr_en,
   output logic [ADDR_WIDTH-2:0]   ram0_waddr,
   output logic [DATA_WIDTH/2-1:0] ram0_wdata,
   output logic                    ram1_wr_en,
   output logic [ADDR_WIDTH-2:0]   ram1_waddr,
   output logic [DATA_WIDTH/2-1:0] ram1_wdata
);
   // state     | meaning
   // S_IDLE    | no capture since reset
   // S_ARM     | started, waiting for cap_trig (trigger build only)
   // S_CAPTURE | writing valid samples
   // S_DONE    | capture ended, results held until next start
   localparam int HW = DATA_WIDTH / 2;
   localparam int RW = ADDR_WIDTH - 1;

   typedef enum logic [1:0] {S_IDLE, S_ARM, S_CAPTURE, S_DONE} state_t;

   state_t                state, state_nxt;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [ADDR_WIDTH-1:0] max_q;
   logic [ADDR_WIDTH-1:0] eff_max;
   logic                  mode_q;
   logic                  loop_q;
   logic                  final_q;
   logic                  start_ok;
   logic                  trig_ok;
   logic                  wr_issue;
   logic                  at_max;

   always_comb begin
      eff_max  = mode_q ? {1'b0, max_q[RW-1:0]} : max_q;
      at_max   = (wr_addr == eff_max);
      start_ok = capture_start && !capture_stop && (state == S_IDLE || state == S_DONE);
`ifdef CAP_WR_TRIG_EN
      trig_ok  = (state == S_ARM) && cap_trig;
`else
      trig_ok  = 1'b0;
`endif
      // final_q marks that the single-shot last write is already out; no further writes
      wr_issue = adc_vld && !capture_stop &&
                 (((state == S_CAPTURE) && !final_q) || trig_ok);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE, S_DONE: begin
`ifdef CAP_WR_TRIG_EN
            if (start_ok) state_nxt = S_ARM;
`else
            if (start_ok) state_nxt = S_CAPTURE;
`endif
         end
         S_ARM: begin
`ifdef CAP_WR_TRIG_EN
            if (capture_stop)  state_nxt = S_DONE;
            else if (cap_trig) state_nxt = S_CAPTURE;
`else
            state_nxt = S_IDLE;
`endif
         end
         S_CAPTURE: begin
            if (capture_stop || final_q) state_nxt = S_DONE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign capture_busy = (state == S_ARM) || (state == S_CAPTURE);
   assign capture_done = (state == S_DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_addr           <= '0;
         max_q             <= '0;
         mode_q            <= 1'b0;
         loop_q            <= 1'b0;
         final_q           <= 1'b0;
         capture_wrap      <= 1'b0;
         capture_last_addr <= '0;
         ram0_wr_en        <= 1'b0;
         ram0_waddr        <= '0;
         ram0_wdata        <= '0;
         ram1_wr_en        <= 1'b0;
         ram1_waddr        <= '0;
         ram1_wdata        <= '0;
      end else begin
         ram0_wr_en <= 1'b0;
         ram1_wr_en <= 1'b0;
         if (start_ok) begin
            wr_addr      <= '0;
            final_q      <= 1'b0;
            capture_wrap <= 1'b0;
            max_q        <= capture_max_addr;
            mode_q       <= store_mode;
            loop_q       <= capture_loop;
         end else if (wr_issue) begin
            capture_last_addr <= wr_addr;
            if (at_max) begin
               if (loop_q) begin
                  wr_addr      <= '0;
                  capture_wrap <= 1'b1;
               end else begin
                  final_q <= 1'b1;
               end
            end else begin
               wr_addr <= wr_addr + 1'b1;
            end
            if (mode_q) begin
               ram0_wr_en <= 1'b1;
               ram0_waddr <= wr_addr[RW-1:0];
               ram0_wdata <= adc_data[HW-1:0];
               ram1_wr_en <= 1'b1;
               ram1_waddr <= wr_addr[RW-1:0];
               ram1_wdata <= adc_data[DATA_WIDTH-1:HW];
            end else if (wr_addr[ADDR_WIDTH-1]) begin
               ram1_wr_en <= 1'b1;
               ram1_waddr <= wr_addr[RW-1:0];
               ram1_wdata <= adc_data[HW-1:0];
            end else begin
               ram0_wr_en <= 1'b1;
               ram0_waddr <= wr_addr[RW-1:0];
               ram0_wdata <= adc_data[HW-1:0];
            end
         end
      end
   end
endmodule
